// File: rtl/shot_trajectory.sv
// Animates the ball from the penalty spot to the latched shot target over 2^FLIGHT_LOG2 frames,
// then judges goal/save against the keeper glove and rests the ball at the target for HOLD_FRAMES.
module shot_trajectory #(
    parameter int START_X      = 512,
    parameter int START_Y      = 700,
    parameter int FLIGHT_LOG2  = 5,
    parameter int HOLD_FRAMES  = 60,
    parameter int GLOVE_HALF_W = 64,
    parameter int GLOVE_HALF_H = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] shot_xpos,
    input  logic [11:0] shot_ypos,
    input  logic        shot_start,
    input  logic        frame_tick,
    input  logic [11:0] keeper_xpos,
    input  logic [11:0] keeper_ypos,
    output logic [11:0] ball_xpos,
    output logic [11:0] ball_ypos,
    output logic        busy,
    output logic        shot_done,
    output logic        goal
);

    localparam int AW = 13 + FLIGHT_LOG2 + 1;
    localparam int KW = FLIGHT_LOG2 + 1;
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    typedef enum logic [1:0] {S_IDLE, S_FLY, S_DECIDE, S_HOLD} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [11:0]           r_tgt_x, r_tgt_y;
    logic signed [12:0]    r_dx, r_dy;
    logic signed [AW-1:0]  r_acc_x, r_acc_y;
    logic [KW-1:0]         r_k;
    logic [HW-1:0]         r_hold;
    logic [11:0]           r_ball_x, r_ball_y;
    logic                  r_busy, r_shot_done, r_goal;

    logic signed [AW-1:0]  w_dx_ext, w_dy_ext;
    logic signed [AW-1:0]  w_acc_x_nxt, w_acc_y_nxt;
    logic [11:0]           w_ball_x_nxt, w_ball_y_nxt;
    logic                  w_last_tick, w_hold_last;
    logic signed [12:0]    w_kdx, w_kdy;
    logic [12:0]           w_kdx_abs, w_kdy_abs;
    logic                  w_saved;

    assign w_dx_ext    = {{(AW-13){r_dx[12]}}, r_dx};
    assign w_dy_ext    = {{(AW-13){r_dy[12]}}, r_dy};
    assign w_acc_x_nxt = r_acc_x + w_dx_ext;
    assign w_acc_y_nxt = r_acc_y + w_dy_ext;

    // Arithmetic shift floors the fraction, so the ball lands exactly on target at the last frame.
    assign w_ball_x_nxt = 12'(AW'(START_X) + (w_acc_x_nxt >>> FLIGHT_LOG2));
    assign w_ball_y_nxt = 12'(AW'(START_Y) + (w_acc_y_nxt >>> FLIGHT_LOG2));

    assign w_last_tick = (r_k == KW'((2 ** FLIGHT_LOG2) - 1));
    assign w_hold_last = (r_hold == HW'(HOLD_FRAMES - 1));

    assign w_kdx     = $signed({1'b0, r_tgt_x}) - $signed({1'b0, keeper_xpos});
    assign w_kdy     = $signed({1'b0, r_tgt_y}) - $signed({1'b0, keeper_ypos});
    assign w_kdx_abs = w_kdx[12] ? 13'(-w_kdx) : 13'(w_kdx);
    assign w_kdy_abs = w_kdy[12] ? 13'(-w_kdy) : 13'(w_kdy);
    assign w_saved   = (w_kdx_abs <= 13'(GLOVE_HALF_W)) && (w_kdy_abs <= 13'(GLOVE_HALF_H));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (shot_start) w_state_nxt = S_FLY;
            S_FLY:    if (frame_tick && w_last_tick) w_state_nxt = S_DECIDE;
            S_DECIDE: w_state_nxt = S_HOLD;
            S_HOLD:   if (frame_tick && w_hold_last) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tgt_x     <= '0;
            r_tgt_y     <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_acc_x     <= '0;
            r_acc_y     <= '0;
            r_k         <= '0;
            r_hold      <= '0;
            r_ball_x    <= 12'(START_X);
            r_ball_y    <= 12'(START_Y);
            r_busy      <= 1'b0;
            r_shot_done <= 1'b0;
            r_goal      <= 1'b0;
        end else begin
            r_shot_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ball_x <= 12'(START_X);
                    r_ball_y <= 12'(START_Y);
                    r_busy   <= 1'b0;
                    if (shot_start) begin
                        r_tgt_x <= shot_xpos;
                        r_tgt_y <= shot_ypos;
                        r_dx    <= $signed({1'b0, shot_xpos}) - 13'(START_X);
                        r_dy    <= $signed({1'b0, shot_ypos}) - 13'(START_Y);
                        r_acc_x <= '0;
                        r_acc_y <= '0;
                        r_k     <= '0;
                        r_goal  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_FLY: begin
                    if (frame_tick) begin
                        r_k      <= r_k + 1'b1;
                        r_acc_x  <= w_acc_x_nxt;
                        r_acc_y  <= w_acc_y_nxt;
                        r_ball_x <= w_ball_x_nxt;
                        r_ball_y <= w_ball_y_nxt;
                    end
                end
                S_DECIDE: begin
                    r_goal      <= !w_saved;
                    r_shot_done <= 1'b1;
                    r_hold      <= '0;
                end
                S_HOLD: begin
                    if (frame_tick) r_hold <= r_hold + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ball_xpos = r_ball_x;
    assign ball_ypos = r_ball_y;
    assign busy      = r_busy;
    assign shot_done = r_shot_done;
    assign goal      = r_goal;

endmodule

// File: tb/tb_shot_trajectory.sv
// Random and directed shots checked against an arithmetic model of the ball flight and save rule.
module tb_shot_trajectory;

    localparam int SX = 512;
    localparam int SY = 700;
    localparam int NF = 32;
    localparam int NH = 60;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] shot_xpos, shot_ypos, keeper_xpos, keeper_ypos;
    logic        shot_start, frame_tick;
    logic [11:0] ball_xpos, ball_ypos;
    logic        busy, shot_done, goal;

    int total = 0;
    int bad   = 0;
    int done_pulses = 0;

    always #5 clk = ~clk;

    shot_trajectory dut (
        .clk        (clk),
        .rst        (rst),
        .shot_xpos  (shot_xpos),
        .shot_ypos  (shot_ypos),
        .shot_start (shot_start),
        .frame_tick (frame_tick),
        .keeper_xpos(keeper_xpos),
        .keeper_ypos(keeper_ypos),
        .ball_xpos  (ball_xpos),
        .ball_ypos  (ball_ypos),
        .busy       (busy),
        .shot_done  (shot_done),
        .goal       (goal)
    );

    always @(posedge clk) if (shot_done === 1'b1) done_pulses++;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int ref_pos(input int s, input int t, input int j);
        return s + fdiv((t - s) * j, NF);
    endfunction

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_shot(input int tx, input int ty, input int kx, input int ky,
                            input bit disturb, input bit tick_at_launch);
        int p0;
        int exp_goal;
        exp_goal = !((iabs(tx - kx) <= 64) && (iabs(ty - ky) <= 64));
        keeper_xpos = 12'(kx);
        keeper_ypos = 12'(ky);
        shot_xpos   = 12'(tx);
        shot_ypos   = 12'(ty);
        shot_start  = 1'b1;
        frame_tick  = tick_at_launch;
        @(negedge clk);
        shot_start = 1'b0;
        frame_tick = 1'b0;
        p0 = done_pulses;
        chk("busy_launch", int'(busy), 1);
        chk("goal_clear", int'(goal), 0);
        chk("launch_x", int'(ball_xpos), SX);
        for (int j = 1; j <= NF; j++) begin
            idle($urandom_range(0, 2));
            if (disturb) begin
                shot_xpos   = 12'($urandom_range(0, 4095));
                shot_ypos   = 12'($urandom_range(0, 4095));
                keeper_xpos = 12'($urandom_range(0, 4095));
                keeper_ypos = 12'($urandom_range(0, 4095));
            end
            frame_tick = 1'b1;
            shot_start = disturb;
            @(negedge clk);
            frame_tick = 1'b0;
            shot_start = 1'b0;
            chk("fly_x", int'(ball_xpos), ref_pos(SX, tx, j));
            chk("fly_y", int'(ball_ypos), ref_pos(SY, ty, j));
            if (tx == 40 && ty == 130 && j == 16) begin
                chk("half_x", int'(ball_xpos), 276);
                chk("half_y", int'(ball_ypos), 415);
            end
            if (j < NF) chk("no_done_fly", int'(shot_done), 0);
        end
        keeper_xpos = 12'(kx);
        keeper_ypos = 12'(ky);
        @(negedge clk);
        chk("done_pulse", int'(shot_done), 1);
        chk("goal", int'(goal), exp_goal);
        @(negedge clk);
        chk("done_clear", int'(shot_done), 0);
        for (int h = 1; h <= NH; h++) begin
            idle($urandom_range(0, 1));
            frame_tick = 1'b1;
            shot_start = disturb;
            @(negedge clk);
            frame_tick = 1'b0;
            shot_start = 1'b0;
            chk("hold_busy", int'(busy), 1);
            chk("hold_x", int'(ball_xpos), tx);
            chk("hold_y", int'(ball_ypos), ty);
            chk("hold_goal", int'(goal), exp_goal);
        end
        @(negedge clk);
        chk("ret_busy", int'(busy), 0);
        chk("ret_x", int'(ball_xpos), SX);
        chk("ret_y", int'(ball_ypos), SY);
        chk("goal_held", int'(goal), exp_goal);
        chk("done_count", done_pulses - p0, 1);
    endtask

    initial begin
        int tx, ty, kx, ky, p0;
        rst = 1'b1;
        shot_xpos = '0; shot_ypos = '0; keeper_xpos = '0; keeper_ypos = '0;
        shot_start = 1'b0; frame_tick = 1'b0;
        idle(2);
        chk("rst_x", int'(ball_xpos), SX);
        chk("rst_y", int'(ball_ypos), SY);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(shot_done), 0);
        chk("rst_goal", int'(goal), 0);
        rst = 1'b0;
        idle(1);

        run_shot(40, 130, 60, 150, 1'b0, 1'b0);
        run_shot(40, 130, 600, 400, 1'b0, 1'b0);
        run_shot(40, 130, 104, 194, 1'b0, 1'b0);
        run_shot(40, 130, 105, 130, 1'b0, 1'b0);
        run_shot(511, 700, 511, 700, 1'b0, 1'b0);
        run_shot(1000, 200, 990, 230, 1'b1, 1'b1);

        // Abandon a flight part-way with reset.
        shot_xpos = 12'd100; shot_ypos = 12'd100; shot_start = 1'b1;
        @(negedge clk);
        shot_start = 1'b0;
        p0 = done_pulses;
        repeat (10) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
        chk("pre_rst_x", int'(ball_xpos), ref_pos(SX, 100, 10));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_x", int'(ball_xpos), SX);
        chk("mid_rst_y", int'(ball_ypos), SY);
        chk("mid_rst_busy", int'(busy), 0);
        repeat (40) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
        chk("mid_rst_nodone", done_pulses - p0, 0);
        chk("mid_rst_idle_x", int'(ball_xpos), SX);
        run_shot(300, 50, 0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 5; n++) begin
            tx = int'($urandom_range(0, 4095));
            ty = int'($urandom_range(0, 4095));
            if ($urandom_range(0, 1) == 1) begin
                kx = tx + int'($urandom_range(0, 140)) - 70;
                ky = ty + int'($urandom_range(0, 140)) - 70;
            end else begin
                kx = int'($urandom_range(0, 4095));
                ky = int'($urandom_range(0, 4095));
            end
            kx = (kx < 0) ? 0 : ((kx > 4095) ? 4095 : kx);
            ky = (ky < 0) ? 0 : ((ky > 4095) ? 4095 : ky);
            run_shot(tx, ty, kx, ky, n[0], n[1]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/shot_trajectory.md
# shot_trajectory

Consumes the shot target produced by the shot-direction controller and animates the ball from the penalty spot to that target over a fixed number of video frames. It publishes the live ball position to the ball-drawing stage. At arrival it compares the target with the keeper glove position and reports goal or save to the game-control logic. Sits between shot-direction control (upstream) and ball draw / score logic (downstream).

## Interface
- START_X, 512, ball x at penalty spot (pixels)
- START_Y, 700, ball y at penalty spot (pixels)
- FLIGHT_LOG2, 5, flight length = 2^FLIGHT_LOG2 frames (32)
- HOLD_FRAMES, 60, frames the ball rests at target after arrival
- GLOVE_HALF_W, 64, keeper save half-width (pixels)
- GLOVE_HALF_H, 64, keeper save half-height (pixels)

- clk  in  1  system clock (pixel clock domain)
- rst  in  1  synchronous, active-high reset
- shot_xpos  in  12  target x from shot-direction controller
- shot_ypos  in  12  target y from shot-direction controller
- shot_start  in  1  one-cycle pulse: launch a shot
- frame_tick  in  1  one-cycle pulse per frame (derived from vsync)
- keeper_xpos  in  12  keeper glove centre x
- keeper_ypos  in  12  keeper glove centre y
- ball_xpos  out  12  current ball x
- ball_ypos  out  12  current ball y
- busy  out  1  high from launch until return to IDLE
- shot_done  out  1  one-cycle pulse at arrival decision
- goal  out  1  result, valid when shot_done=1, held until next launch

## Operation
- States: IDLE, FLY, DECIDE, HOLD.
- IDLE: ball = (START_X, START_Y), busy=0. On shot_start: latch tgt_x/tgt_y from shot_xpos/shot_ypos, compute signed 13-bit dx = tgt_x − START_X, dy = tgt_y − START_Y, clear acc_x/acc_y and frame counter k, clear goal, go FLY.
- FLY: on each frame_tick: k ← k+1, acc_x ← acc_x + dx, acc_y ← acc_y + dy (signed, 13+FLIGHT_LOG2+1 bits, no overflow possible). ball_xpos = START_X + (acc_x >>> FLIGHT_LOG2), arithmetic shift (floor); same for y. Result always lies between start and target, no clamping.
- When k reaches 2^FLIGHT_LOG2, ball equals target exactly; go DECIDE.
- DECIDE (one cycle): saved = |tgt_x − keeper_xpos| ≤ GLOVE_HALF_W AND |tgt_y − keeper_ypos| ≤ GLOVE_HALF_H (13-bit signed differences, inclusive bounds). goal ← !saved; shot_done=1; go HOLD with hold counter cleared.
- HOLD: ball stays at target; count frame_ticks; after HOLD_FRAMES ticks, go IDLE (ball returns to start).
- shot_start outside IDLE is ignored; latched target never changes mid-flight.
- frame_tick coincident with shot_start in IDLE is ignored (k stays 0).
- Keeper position is sampled only in DECIDE, never during flight.

## Timing
- All outputs registered. Reset values: ball_xpos=START_X, ball_ypos=START_Y, busy=0, shot_done=0, goal=0, state IDLE, counters 0.
- shot_start at cycle N → busy=1 at N+1.
- frame_tick at cycle M in FLY → new ball position visible at M+1.
- Final tick at cycle M → ball=target at M+1, shot_done=1 at M+2 for exactly one cycle, goal valid at M+2 and held.
- HOLD → IDLE on the cycle after the HOLD_FRAMES-th tick; busy=0 and ball=start one cycle later.
- rst asserted in any state returns to reset values on the next edge; a partial flight is discarded, no shot_done issued.

## Test plan
- Reset: rst high 2 cycles → ball=(512,700), busy=0, shot_done=0, goal=0.
- Launch target (40,130), 16 frame_ticks → ball=(276,415); after 32 ticks → ball=(40,130), shot_done pulses once.
- Keeper (60,150) at arrival → goal=0; repeat with keeper (600,400) → goal=1; keeper (104,194) (both bounds exactly 64) → goal=0; keeper (105,130) → goal=1.
- Negative floor: target (511,700), 1 tick → ball_x = 512 + floor(−1/32) = 511.
- shot_start pulses during FLY and HOLD, and target inputs changed mid-flight → trajectory and result unchanged; shot_start coincident with frame_tick in IDLE → k=0 after launch.
- rst asserted after 10 ticks of a flight → ball=(512,700), busy=0, no shot_done; new shot afterwards completes normally.
